pattern_match_ctrl: RTL
=======================

// Module: pattern_match_ctrl
// PURPOSE
//  Run-time configurable controller for serial pattern detection; the programmable successor to the fixed 110100 detector.
//  Holds the pattern/length/limit/window config, arms on start, and hunts the serial bit stream.
//  Counts matches; finishes on match limit (done), beat-window expiry (timeout) or abort.
//  Sits between the serial front end and the status/interrupt logic.
// PARAMETERS
//  PAT_W  6  max pattern length in bits (2..15)
//  CNT_W  8  width of match counter, limit and window registers
// PORTS
//  clk          in   1      single clock, all logic on posedge
//  rst          in   1      synchronous, active-low reset
//  cfg_we       in   1      load cfg_* into config regs; honoured only in IDLE
//  cfg_pattern  in   PAT_W  pattern; bit[len-1] is received first, bit[0] last
//  cfg_len      in   4      pattern length; 0 -> 1, >PAT_W -> PAT_W (clamped at load)
//  cfg_limit    in   CNT_W  matches to finish; 0 = free-run (never done on count)
//  cfg_window   in   CNT_W  max in_valid beats per run; 0 = no timeout
//  start        in   1      arm a run; honoured only in IDLE
//  abort        in   1      cancel a run; honoured only in HUNT
//  in_valid     in   1      serial bit qualifier
//  in           in   1      serial data bit
//  busy         out  1      1 while in HUNT or DONE
//  match_pulse  out  1      1-cycle pulse per detected match
//  match_count  out  CNT_W  matches in current/last run
//  done         out  1      1-cycle pulse on run completion (limit or timeout)
//  timeout      out  1      1-cycle pulse, coincident with done, on window expiry
// BEHAVIOUR
//  Reset (rst=0 at a posedge): state=IDLE; all outputs 0; history cleared.
//   Config defaults: pattern=6'b110100, len=6, limit=1, window=0.
//  FSM: IDLE -start-> HUNT; HUNT -limit|window-> DONE; HUNT -abort-> IDLE; DONE -> IDLE after 1 cycle.
//  IDLE: cfg_we loads regs (clamping len). start wins over cfg_we in the same cycle; that cfg write is dropped.
//   start: clear shreg, bits_seen, beat_cnt, match_count; busy=1 from next cycle.
//  HUNT, per in_valid beat:
//   shreg <= {shreg,in}. bits_seen saturates at len. beat_cnt += 1.
//   Match when bits_seen+1 >= len and the low len bits of {shreg,in} equal pattern[len-1:0].
//   On match, at the same edge: match_pulse=1 and match_count+1.
//    match_count wraps modulo 2^CNT_W when limit=0.
//   No in_valid: no state change.
//  Latency: match_pulse asserts the cycle after the completing beat.
//  Limit: when match_count reaches limit (limit!=0) -> DONE. done=1 in the DONE cycle; then IDLE, busy=0.
//  Window: when beat_cnt reaches window (window!=0) without reaching limit -> DONE with timeout=1 and done=1.
//  Simultaneous events:
//   Match reaching limit on the window-expiry beat: counts as limit; timeout stays 0.
//   abort with a match in the same cycle: match discarded; no match_pulse, no count.
//   -> IDLE next cycle, done=0; match_count holds its last value.
//  start/cfg_we outside IDLE: ignored. abort outside HUNT: ignored.
//  Reset mid-run: immediate return to reset state; config reverts to defaults.
// CONFIGURATION
//  PMC_OVERLAP_EN defined: overlapping matches allowed; history is kept after a match.
//  Not defined (default): bits_seen clears on each match (shreg value irrelevant).
//   The next match needs len fresh beats.
// TESTING
//  1 Defaults, start, beats 1,1,0,1,0,0 -> match_pulse after 6th beat, count=1, done next cycle, busy->0.
//  2 pattern=3'b101 len=3 limit=0, beats 1,0,1,0,1 -> count=2 with PMC_OVERLAP_EN, count=1 without.
//  3 pattern=3'b101 len=3 limit=2, beats 1,0,1,1,0,1 -> done after 6th beat, count=2, timeout=0.
//  4 window=4, beats 0,0,0,0 -> timeout=1 and done=1 one cycle after 4th beat, count=0.
//  5 Collisions:
//   window=6 with test-1 stream -> done, timeout=0.
//   abort on 6th beat -> no match_pulse, no done, IDLE.
//  6 rst=0 for 1 cycle mid-HUNT after cfg len=3 -> outputs 0, IDLE; next run uses 110100.
//   start+cfg_we together -> cfg ignored.

Source files
------------

// File: rtl/pattern_match_ctrl.sv
// Run-time configurable serial pattern detector: holds pattern/length/limit/window, hunts on start.
// Define PMC_OVERLAP_EN to keep bit history across matches so overlapping matches are counted.
module pattern_match_ctrl #(
  parameter int PAT_W = 6,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [3:0]       cfg_len,
  input  logic [CNT_W-1:0] cfg_limit,
  input  logic [CNT_W-1:0] cfg_window,
  input  logic             start,
  input  logic             abort,
  input  logic             in_valid,
  input  logic             in,
  output logic             busy,
  output logic             match_pulse,
  output logic [CNT_W-1:0] match_count,
  output logic             done,
  output logic             timeout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HUNT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0]       PAT_W_L = 4'(PAT_W);
  localparam logic [3:0]       DEF_LEN = (PAT_W_L < 4'd6) ? PAT_W_L : 4'd6;
  localparam logic [PAT_W-1:0] DEF_PAT = PAT_W'(6'b110100);

  // Length 0 means 1; anything beyond the shift register width is capped to it.
  function automatic logic [3:0] clamp_len(input logic [3:0] l);
    if (l == 4'd0) begin
      clamp_len = 4'd1;
    end else if (l > PAT_W_L) begin
      clamp_len = PAT_W_L;
    end else begin
      clamp_len = l;
    end
  endfunction

  function automatic logic [PAT_W-1:0] len_mask(input logic [3:0] l);
    for (int i = 0; i < PAT_W; i++) begin
      len_mask[i] = (4'(i) < l);
    end
  endfunction

  state_t           state_r;
  logic [PAT_W-1:0] pat_r;
  logic [3:0]       len_r;
  logic [CNT_W-1:0] limit_r;
  logic [CNT_W-1:0] window_r;
  logic [PAT_W-1:0] shreg_r;
  logic [3:0]       bits_seen_r;
  logic [CNT_W-1:0] beat_cnt_r;

  logic [PAT_W-1:0] sh_next_s;
  logic [PAT_W-1:0] mask_s;
  logic             hit_s;
  logic [3:0]       bits_sat_s;
  logic [3:0]       bits_next_s;
  logic [CNT_W-1:0] count_next_s;
  logic [CNT_W-1:0] beat_next_s;
  logic             lim_hit_s;
  logic             win_hit_s;

  // Evaluate what a beat arriving this cycle would do to history, counters and run status.
  always_comb begin
    sh_next_s    = {shreg_r[PAT_W-2:0], in};
    mask_s       = len_mask(len_r);
    hit_s        = (bits_seen_r >= (len_r - 4'd1)) &&
                   ((sh_next_s & mask_s) == (pat_r & mask_s));
    bits_sat_s   = (bits_seen_r >= len_r) ? len_r : (bits_seen_r + 4'd1);
    count_next_s = hit_s ? (match_count + CNT_W'(1)) : match_count;
    beat_next_s  = beat_cnt_r + CNT_W'(1);
    lim_hit_s    = hit_s && (limit_r != {CNT_W{1'b0}}) && (count_next_s == limit_r);
    win_hit_s    = !lim_hit_s && (window_r != {CNT_W{1'b0}}) && (beat_next_s == window_r);
    if (hit_s) begin
`ifdef PMC_OVERLAP_EN
      bits_next_s = bits_sat_s;
`else
      bits_next_s = 4'd0;
`endif
    end else begin
      bits_next_s = bits_sat_s;
    end
  end

  // Control FSM with configuration, history and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r     <= IDLE;
      pat_r       <= DEF_PAT;
      len_r       <= DEF_LEN;
      limit_r     <= CNT_W'(1);
      window_r    <= {CNT_W{1'b0}};
      shreg_r     <= {PAT_W{1'b0}};
      bits_seen_r <= 4'd0;
      beat_cnt_r  <= {CNT_W{1'b0}};
      match_count <= {CNT_W{1'b0}};
      busy        <= 1'b0;
      match_pulse <= 1'b0;
      done        <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      match_pulse <= 1'b0;
      done        <= 1'b0;
      timeout     <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r     <= HUNT;
            busy        <= 1'b1;
            shreg_r     <= {PAT_W{1'b0}};
            bits_seen_r <= 4'd0;
            beat_cnt_r  <= {CNT_W{1'b0}};
            match_count <= {CNT_W{1'b0}};
          end else if (cfg_we) begin
            pat_r    <= cfg_pattern;
            len_r    <= clamp_len(cfg_len);
            limit_r  <= cfg_limit;
            window_r <= cfg_window;
          end
        end
        HUNT: begin
          // Abort outranks any beat in the same cycle, so a coincident match is dropped.
          if (abort) begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end else if (in_valid) begin
            shreg_r     <= sh_next_s;
            bits_seen_r <= bits_next_s;
            beat_cnt_r  <= beat_next_s;
            match_count <= count_next_s;
            match_pulse <= hit_s;
            if (lim_hit_s || win_hit_s) begin
              state_r <= DONE;
              done    <= 1'b1;
              timeout <= win_hit_s;
            end
          end
        end
        DONE: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
